// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB TX FIFO drain path.
// State encoding, PID codes and CRC16 parameters.
package usb_tx_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_LVL,
    S_PID,
    S_DATA,
    S_CRC_LO,
    S_CRC_HI,
    S_DONE,
    S_FLUSH
  } state_t;

  localparam logic [3:0] PID_DATA0 = 4'h3;
  localparam logic [3:0] PID_DATA1 = 4'hB;
  localparam logic [3:0] PID_DATA2 = 4'h7;
  localparam logic [3:0] PID_MDATA = 4'hF;

  localparam logic [15:0] CRC16_POLY_R = 16'hA001;
  localparam logic [15:0] CRC16_INIT   = 16'hFFFF;

  function automatic logic [7:0] pid_byte(
    input logic [3:0] p
  );
    return {~p, p};
  endfunction

endpackage

// File: rtl/usb_crc16_byte.sv
// One-byte step of the USB CRC16, reflected form.
// Bits are folded in LSB first.
module usb_crc16_byte
  import usb_tx_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [7:0]  data,
  output logic [15:0] crc_out
);

  logic [15:0] c;

  always_comb begin
    c = crc_in;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) begin
        c = (c >> 1) ^ CRC16_POLY_R;
      end else begin
        c = c >> 1;
      end
    end
    crc_out = c;
  end

endmodule

// File: rtl/usb_tx_fifo_reader.sv
// Drains one payload from the TX FIFO into a PID/data/CRC16 packet.
// Define USB_TX_FLUSH_ON_ABORT_EN to discard unread bytes on abort.
module usb_tx_fifo_reader
  import usb_tx_pkg::*;
#(
  parameter int MAX_PL = 64,
  parameter int LEN_W  = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             send,
  input  logic [3:0]       pid,
  input  logic [LEN_W-1:0] pl_len,
  input  logic             abort,
  input  logic [7:0]       fifo_dout,
  input  logic             fifo_empty,
  input  logic [LEN_W-1:0] fifo_level,
  output logic             fifo_re,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic             underrun,
  output logic             len_err
);

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_PL);
  localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

`ifdef USB_TX_FLUSH_ON_ABORT_EN
  localparam state_t KILL_ST = S_FLUSH;
`else
  localparam state_t KILL_ST = S_IDLE;
`endif

  state_t           state;
  logic [3:0]       pid_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] rd_left;
  logic [LEN_W-1:0] wr_left;
  logic [15:0]      crc;
  logic [15:0]      crc_nxt;
  logic [7:0]       hold;
  logic [7:0]       td_q;
  logic             hold_vld;
  logic             pend;
  logic             tv_q;
  logic             in_data;
  logic             ent;
  logic             hs;
  logic             dry;
  logic             rd_ok;
  logic             active;
  logic             kill;

  // A popped byte is either in flight (pend) or parked in hold.
  assign in_data = (state == S_DATA);
  assign ent     = hold_vld | pend;
  assign tx_valid = in_data ? ent : tv_q;
  assign tx_data  = !in_data ? td_q :
                    (pend ? fifo_dout : hold);
  assign hs      = tx_valid & tx_ready;
  assign busy    = (state != S_IDLE) &&
                   (state != S_DONE);
  assign rd_ok   = ~fifo_empty & (rd_left != '0);
  assign dry     = in_data & ~ent & fifo_empty &
                   (rd_left != '0);
  assign active  = state inside {S_WAIT_LVL, S_PID,
                   S_DATA, S_CRC_LO, S_CRC_HI};
  assign kill    = (abort & active) | dry;

  always_comb begin
    fifo_re = 1'b0;
    unique case (state)
      S_PID:   fifo_re = rd_ok & ~abort & ~ent;
      S_DATA:  fifo_re = rd_ok & ~abort &
                         (~ent | hs);
`ifdef USB_TX_FLUSH_ON_ABORT_EN
      S_FLUSH: fifo_re = rd_ok;
`endif
      default: fifo_re = 1'b0;
    endcase
  end

  usb_crc16_byte u_crc (
    .crc_in  (crc),
    .data    (tx_data),
    .crc_out (crc_nxt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      pid_q    <= '0;
      len_q    <= '0;
      rd_left  <= '0;
      wr_left  <= '0;
      crc      <= CRC16_INIT;
      hold     <= '0;
      hold_vld <= 1'b0;
      pend     <= 1'b0;
      td_q     <= '0;
      tv_q     <= 1'b0;
      done     <= 1'b0;
      aborted  <= 1'b0;
      underrun <= 1'b0;
      len_err  <= 1'b0;
    end else begin
      done     <= 1'b0;
      aborted  <= 1'b0;
      underrun <= 1'b0;
      len_err  <= 1'b0;
      pend     <= fifo_re & (state != S_FLUSH);
      if (fifo_re && rd_left != '0) begin
        rd_left <= rd_left - ONE;
      end
      if (in_data && hs) begin
        hold_vld <= 1'b0;
      end else if (pend) begin
        hold     <= fifo_dout;
        hold_vld <= 1'b1;
      end
      unique case (state)
        S_IDLE: begin
          if (send && !abort) begin
            if (pl_len > MAX_LEN) begin
              len_err <= 1'b1;
            end else begin
              pid_q    <= pid;
              len_q    <= pl_len;
              rd_left  <= pl_len;
              wr_left  <= pl_len;
              crc      <= CRC16_INIT;
              hold_vld <= 1'b0;
              state    <= S_WAIT_LVL;
            end
          end
        end
        S_WAIT_LVL: begin
          if (fifo_level >= len_q) begin
            tv_q  <= 1'b1;
            td_q  <= pid_byte(pid_q);
            state <= S_PID;
          end
        end
        S_PID: begin
          if (hs) begin
            if (len_q == '0) begin
              td_q  <= ~crc[7:0];
              state <= S_CRC_LO;
            end else begin
              tv_q  <= 1'b0;
              state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (hs) begin
            crc <= crc_nxt;
            if (wr_left != '0) begin
              wr_left <= wr_left - ONE;
            end
            if (wr_left <= ONE) begin
              tv_q  <= 1'b1;
              td_q  <= ~crc_nxt[7:0];
              state <= S_CRC_LO;
            end
          end
        end
        S_CRC_LO: begin
          if (hs) begin
            td_q  <= ~crc[15:8];
            state <= S_CRC_HI;
          end
        end
        S_CRC_HI: begin
          if (hs) begin
            tv_q  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end
        end
        S_DONE: state <= S_IDLE;
        S_FLUSH: begin
          if (rd_left == '0 || fifo_empty) begin
            state <= S_IDLE;
          end
        end
      endcase
      // Abort and underrun override whatever the state did.
      if (kill) begin
        state    <= KILL_ST;
        tv_q     <= 1'b0;
        hold_vld <= 1'b0;
        done     <= 1'b0;
        aborted  <= 1'b1;
        underrun <= dry;
      end
    end
  end

endmodule

// File: tb/tb_usb_tx_fifo_reader.sv
// Directed bench for usb_tx_fifo_reader with a byte scoreboard.
// Expected bytes and CRC come from a local model.
module tb_usb_tx_fifo_reader;
  import usb_tx_pkg::*;

  localparam int LEN_W = 11;
`ifdef USB_TX_FLUSH_ON_ABORT_EN
  localparam int AB_RE   = 4;
  localparam int AB_LEFT = 0;
`else
  localparam int AB_RE   = 2;
  localparam int AB_LEFT = 2;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             send;
  logic [3:0]       pid;
  logic [LEN_W-1:0] pl_len;
  logic             abort;
  logic [7:0]       fifo_dout = 8'h00;
  logic             fifo_empty;
  logic [LEN_W-1:0] fifo_level;
  logic             fifo_re;
  logic [7:0]       tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic             busy;
  logic             done;
  logic             aborted;
  logic             underrun;
  logic             len_err;

  always #5 clk = ~clk;

  usb_tx_fifo_reader #(
    .MAX_PL (64),
    .LEN_W  (LEN_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .send       (send),
    .pid        (pid),
    .pl_len     (pl_len),
    .abort      (abort),
    .fifo_dout  (fifo_dout),
    .fifo_empty (fifo_empty),
    .fifo_level (fifo_level),
    .fifo_re    (fifo_re),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .busy       (busy),
    .done       (done),
    .aborted    (aborted),
    .underrun   (underrun),
    .len_err    (len_err)
  );

  logic [7:0] mem [0:511];
  int wp = 0;
  int rp = 0;
  int nre = 0;
  logic force_empty = 1'b0;

  assign fifo_empty = force_empty | (wp == rp);
  assign fifo_level = LEN_W'(wp - rp);

  always @(posedge clk) begin
    if (fifo_re) begin
      if (rp != wp) begin
        fifo_dout <= mem[rp];
        rp <= rp + 1;
      end
      nre <= nre + 1;
    end
  end

  logic [7:0] exp_q [$];
  logic [7:0] pl [$];
  int total = 0;
  int bad = 0;
  int ncyc = 0;
  int hs_n = 0;
  int first_hs = 0;
  int last_hs = 0;
  int n_done = 0;
  int n_abt = 0;
  int n_und = 0;
  int n_lerr = 0;
  int n_both = 0;
  logic pv = 1'b0;
  logic [7:0] pd = 8'h00;
  logic chk_done = 1'b0;
  logic arm_abort = 1'b0;

  function automatic logic [15:0] crc_upd(
    input logic [15:0] c,
    input logic [7:0]  d
  );
    logic [15:0] r;
    r = c ^ {8'h00, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
    end
    return r;
  endfunction

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] want
  );
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic mon();
    logic [7:0] e;
    ncyc++;
    if (chk_done) begin
      chk("done_after_last", 32'(done), 1);
      chk_done = 1'b0;
    end
    if (pv) begin
      chk("hold_valid", 32'(tx_valid), 1);
      chk("hold_data", 32'(tx_data), 32'(pd));
    end
    pv = tx_valid & ~tx_ready;
    pd = tx_data;
    if (done) n_done++;
    if (aborted) n_abt++;
    if (underrun) n_und++;
    if (len_err) n_lerr++;
    if (underrun && aborted) n_both++;
    if (tx_valid && tx_ready) begin
      if (hs_n == 0) first_hs = ncyc;
      last_hs = ncyc;
      hs_n++;
      chk("sb_nonempty", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("tx_byte", 32'(tx_data), 32'(e));
        if (exp_q.size() == 0) chk_done = 1'b1;
      end
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    mon();
    if (arm_abort && hs_n == 3) begin
      abort = 1'b1;
      arm_abort = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic load(
    input logic [3:0] p,
    input int         n,
    input bit         rnd
  );
    logic [15:0] c;
    logic [7:0]  b;
    c = 16'hFFFF;
    pl.delete();
    exp_q.delete();
    exp_q.push_back({~p, p});
    for (int i = 0; i < n; i++) begin
      b = rnd ? 8'($urandom_range(0, 255)) : 8'(i + 1);
      pl.push_back(b);
      c = crc_upd(c, b);
      exp_q.push_back(b);
    end
    exp_q.push_back(~c[7:0]);
    exp_q.push_back(~c[15:8]);
  endtask

  task automatic push(input int from, input int to);
    for (int i = from; i < to; i++) begin
      mem[wp] = pl[i];
      wp++;
    end
  endtask

  task automatic go(input logic [3:0] p, input int n);
    pid = p;
    pl_len = LEN_W'(n);
    send = 1'b1;
    hs_n = 0;
    cyc();
    send = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit rnd);
    int d0;
    int k;
    d0 = n_done;
    k = 0;
    while (n_done == d0 && k < budget) begin
      if (rnd) tx_ready = 1'($urandom_range(0, 1));
      cyc();
      k++;
    end
    chk("done_seen", 32'(n_done - d0), 1);
    tx_ready = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0;
    int d0;
    int a0;
    int u0;
    int b0;
    int l0;
    int k;
    bit seen;
    rst = 1'b0;
    send = 1'b0;
    pid = 4'h0;
    pl_len = '0;
    abort = 1'b0;
    tx_ready = 1'b0;
    repeat (2) cyc();
    chk("reset_outs", 32'({tx_valid, fifo_re, busy,
        done, aborted, underrun, len_err, tx_data}), 0);
    rst = 1'b1;
    tx_ready = 1'b1;
    cyc();

    // zero-length packet
    r0 = nre;
    load(PID_DATA0, 0, 0);
    go(PID_DATA0, 0);
    wait_done(20, 0);
    chk("zlp_re", 32'(nre - r0), 0);
    chk("zlp_sb", 32'(exp_q.size()), 0);
    chk("zlp_busy", 32'(busy), 0);

    // 4-byte packet, back to back
    r0 = nre;
    load(PID_DATA1, 4, 0);
    push(0, 4);
    go(PID_DATA1, 4);
    wait_done(30, 0);
    chk("t2_re", 32'(nre - r0), 4);
    chk("t2_b2b", 32'(last_hs - first_hs), 6);
    chk("t2_sb", 32'(exp_q.size()), 0);
    chk("t2_fifo", 32'(wp - rp), 0);

    // level gating
    r0 = nre;
    load(PID_DATA2, 8, 1);
    push(0, 5);
    go(PID_DATA2, 8);
    seen = 1'b0;
    repeat (20) begin
      cyc();
      if (tx_valid || fifo_re) seen = 1'b1;
    end
    chk("gate_quiet", 32'(seen), 0);
    push(5, 8);
    k = 0;
    while (!tx_valid && k < 3) begin
      cyc();
      k++;
    end
    chk("gate_lat", 32'(tx_valid && k <= 2), 1);
    wait_done(40, 0);
    chk("t3_re", 32'(nre - r0), 8);
    chk("t3_sb", 32'(exp_q.size()), 0);

    // max length with random backpressure
    d0 = n_done;
    load(PID_MDATA, 64, 1);
    push(0, 64);
    go(PID_MDATA, 64);
    wait_done(1000, 1);
    repeat (3) cyc();
    chk("t4_done_once", 32'(n_done - d0), 1);
    chk("t4_sb", 32'(exp_q.size()), 0);

    // abort on payload byte 2
    d0 = n_done;
    a0 = n_abt;
    r0 = nre;
    load(PID_DATA0, 4, 0);
    push(0, 4);
    arm_abort = 1'b1;
    go(PID_DATA0, 4);
    k = 0;
    while (!abort && k < 20) begin
      cyc();
      k++;
    end
    chk("abort_hit", 32'(abort), 1);
    chk("abort_txv", 32'(tx_valid), 0);
    chk("abort_pulse", 32'(aborted), 1);
    abort = 1'b0;
    repeat (8) cyc();
    chk("abort_nodone", 32'(n_done - d0), 0);
    chk("abort_once", 32'(n_abt - a0), 1);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_re", 32'(nre - r0), AB_RE);
    chk("abort_left", 32'(wp - rp), AB_LEFT);
    exp_q.delete();
    wp = rp;
    cyc();

    // length error
    r0 = nre;
    l0 = n_lerr;
    go(PID_DATA0, 65);
    chk("lerr_pulse", 32'(len_err), 1);
    chk("lerr_busy", 32'(busy), 0);
    cyc();
    chk("lerr_1cyc", 32'(len_err), 0);
    repeat (3) cyc();
    chk("lerr_re", 32'(nre - r0), 0);
    chk("lerr_once", 32'(n_lerr - l0), 1);

    // reset mid-payload, then a clean packet
    load(PID_DATA1, 8, 1);
    push(0, 8);
    go(PID_DATA1, 8);
    k = 0;
    while (hs_n < 3 && k < 20) begin
      cyc();
      k++;
    end
    rst = 1'b0;
    #1;
    chk("rst_outs", 32'({tx_valid, fifo_re, busy,
        done, aborted, underrun, len_err, tx_data}), 0);
    repeat (2) cyc();
    rst = 1'b1;
    exp_q.delete();
    wp = rp;
    pv = 1'b0;
    cyc();
    load(PID_DATA0, 3, 1);
    push(0, 3);
    go(PID_DATA0, 3);
    wait_done(30, 0);
    chk("post_rst_sb", 32'(exp_q.size()), 0);

    // FIFO runs dry mid-payload
    d0 = n_done;
    u0 = n_und;
    b0 = n_both;
    load(PID_DATA1, 4, 0);
    push(0, 4);
    go(PID_DATA1, 4);
    k = 0;
    while (hs_n < 2 && k < 20) begin
      cyc();
      k++;
    end
    force_empty = 1'b1;
    k = 0;
    while (n_und == u0 && k < 10) begin
      cyc();
      k++;
    end
    chk("und_seen", 32'(n_und - u0), 1);
    chk("und_with_abt", 32'(n_both - b0), 1);
    force_empty = 1'b0;
    repeat (8) cyc();
    chk("und_nodone", 32'(n_done - d0), 0);
    chk("und_busy", 32'(busy), 0);
    exp_q.delete();
    wp = rp;
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
